// File: rtl/stall_flush_ctrl_pkg.sv
// Shared FSM encodings and pipeline stage indices for the stall/flush controller.
package stall_flush_ctrl_pkg;

  typedef enum logic [0:0] {
    ST_IDLE       = 1'b0,
    ST_LOAD_STALL = 1'b1
  } state_e;

  localparam int STAGE_PC    = 0;
  localparam int STAGE_IFID  = 1;
  localparam int STAGE_IDEX  = 2;
  localparam int STAGE_EXMEM = 3;

endpackage

// File: rtl/stall_perf_cnt.sv
// 32-bit saturating event counter; only built when STALL_PERF_EN is defined.
`ifdef STALL_PERF_EN
module stall_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [31:0] count
);

  // Count enabled cycles, sticking at all ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 32'd0;
    end else if (en && (count != 32'hFFFF_FFFF)) begin
      count <= count + 32'd1;
    end else begin
      count <= count;
    end
  end

endmodule
`endif

// File: rtl/stall_flush_ctrl.sv
// Pipeline hold/bubble controller: ram_pause > branch flush > load-use stall.
// Optional performance counters are enabled by the STALL_PERF_EN macro.
module stall_flush_ctrl #(
  parameter int STAGES   = 4,
  parameter int LOAD_LAT = 1,
  parameter int ADDR_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_reg_wr,
  input  logic              ex_is_load,
  input  logic [ADDR_W-1:0] ex_wb_addr,
  input  logic [ADDR_W-1:0] id_rega_addr,
  input  logic [ADDR_W-1:0] id_regb_addr,
  input  logic              id_use_rega,
  input  logic              id_use_regb,
  input  logic              branch_taken,
  input  logic              ram_pause,
  output logic [STAGES-1:0] pause,
  output logic [STAGES-1:0] flush,
  output logic              stall_busy
`ifdef STALL_PERF_EN
  ,
  output logic [31:0]       perf_ram_cyc,
  output logic [31:0]       perf_load_cyc,
  output logic [31:0]       perf_flush_cnt
`endif
);

  import stall_flush_ctrl_pkg::*;

  localparam int CNT_W = $clog2(LOAD_LAT) + 1;
  // First hazard cycle is the IDLE cycle itself, so the counter covers the rest.
  localparam logic [CNT_W-1:0] CNT_INIT = (LOAD_LAT > 1) ? CNT_W'(LOAD_LAT - 2) : '0;

  state_e           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             hazard_s;
  logic             bubble_s;

  assign hazard_s = ex_reg_wr & ex_is_load &
                    ((id_use_rega & (ex_wb_addr == id_rega_addr)) |
                     (id_use_regb & (ex_wb_addr == id_regb_addr)));
  assign bubble_s = (state_r == ST_LOAD_STALL) | hazard_s;

  // Same-cycle pause/flush decode from inputs and current FSM state.
  always_comb begin
    pause = '0;
    flush = '0;
    if (ram_pause) begin
      pause = '1;
    end else if (branch_taken) begin
      flush[STAGE_IFID] = 1'b1;
      flush[STAGE_IDEX] = 1'b1;
    end else if (bubble_s) begin
      pause[STAGE_PC]   = 1'b1;
      pause[STAGE_IFID] = 1'b1;
      flush[STAGE_IDEX] = 1'b1;
    end else begin
      pause = '0;
      flush = '0;
    end
  end

  // Load-use bubble sequencer; frozen by ram_pause, cancelled by a branch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
    end else if (ram_pause) begin
      state_r <= state_r;
      cnt_r   <= cnt_r;
    end else if (branch_taken) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (hazard_s && (LOAD_LAT > 1)) begin
            state_r <= ST_LOAD_STALL;
            cnt_r   <= CNT_INIT;
          end else begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
          end
        end
        ST_LOAD_STALL: begin
          if (cnt_r == '0) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
          end else begin
            state_r <= ST_LOAD_STALL;
            cnt_r   <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  assign stall_busy = (state_r == ST_LOAD_STALL);

`ifdef STALL_PERF_EN
  logic ram_en_s;
  logic load_en_s;
  logic flush_en_s;

  assign ram_en_s   = ram_pause;
  assign load_en_s  = ~ram_pause & ~branch_taken & bubble_s;
  assign flush_en_s = ~ram_pause & branch_taken;

  stall_perf_cnt u_ram_cnt   (.clk(clk), .rst(rst), .en(ram_en_s),   .count(perf_ram_cyc));
  stall_perf_cnt u_load_cnt  (.clk(clk), .rst(rst), .en(load_en_s),  .count(perf_load_cyc));
  stall_perf_cnt u_flush_cnt (.clk(clk), .rst(rst), .en(flush_en_s), .count(perf_flush_cnt));
`endif

endmodule

// File: tb/tb_stall_flush_ctrl.sv
// Directed bench for stall_flush_ctrl: a LOAD_LAT=1 instance driven from a vector
// table and a LOAD_LAT=3 instance driven by hand-written multi-cycle sequences.
module tb_stall_flush_ctrl;

  typedef struct packed {
    logic       ex_reg_wr;
    logic       ex_is_load;
    logic [3:0] ex_wb_addr;
    logic [3:0] id_rega_addr;
    logic [3:0] id_regb_addr;
    logic       id_use_rega;
    logic       id_use_regb;
    logic       branch_taken;
    logic       ram_pause;
  } in_t;

  typedef struct {
    string      name;
    in_t        in;
    logic [3:0] pause;
    logic [3:0] flush;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  in_t  in1;
  in_t  in3;
  logic [3:0] pause1, flush1, pause3, flush3;
  logic       busy1, busy3;
  int n_vec = 0;
  int n_err = 0;
  vec_t vecs[14];
  in_t  idle_in;

`ifdef STALL_PERF_EN
  logic [31:0] ram1, load1, fl1, ram3, load3, fl3;
`endif

  always #5 clk = ~clk;

  stall_flush_ctrl #(.STAGES(4), .LOAD_LAT(1), .ADDR_W(4)) dut1 (
    .clk(clk), .rst(rst),
    .ex_reg_wr(in1.ex_reg_wr), .ex_is_load(in1.ex_is_load), .ex_wb_addr(in1.ex_wb_addr),
    .id_rega_addr(in1.id_rega_addr), .id_regb_addr(in1.id_regb_addr),
    .id_use_rega(in1.id_use_rega), .id_use_regb(in1.id_use_regb),
    .branch_taken(in1.branch_taken), .ram_pause(in1.ram_pause),
    .pause(pause1), .flush(flush1), .stall_busy(busy1)
`ifdef STALL_PERF_EN
    , .perf_ram_cyc(ram1), .perf_load_cyc(load1), .perf_flush_cnt(fl1)
`endif
  );

  stall_flush_ctrl #(.STAGES(4), .LOAD_LAT(3), .ADDR_W(4)) dut3 (
    .clk(clk), .rst(rst),
    .ex_reg_wr(in3.ex_reg_wr), .ex_is_load(in3.ex_is_load), .ex_wb_addr(in3.ex_wb_addr),
    .id_rega_addr(in3.id_rega_addr), .id_regb_addr(in3.id_regb_addr),
    .id_use_rega(in3.id_use_rega), .id_use_regb(in3.id_use_regb),
    .branch_taken(in3.branch_taken), .ram_pause(in3.ram_pause),
    .pause(pause3), .flush(flush3), .stall_busy(busy3)
`ifdef STALL_PERF_EN
    , .perf_ram_cyc(ram3), .perf_load_cyc(load3), .perf_flush_cnt(fl3)
`endif
  );

  function automatic in_t mk(input logic wr, input logic ld, input logic [3:0] wb,
                             input logic [3:0] a, input logic [3:0] b,
                             input logic ua, input logic ub,
                             input logic br, input logic rp);
    in_t r;
    r.ex_reg_wr    = wr;
    r.ex_is_load   = ld;
    r.ex_wb_addr   = wb;
    r.id_rega_addr = a;
    r.id_regb_addr = b;
    r.id_use_rega  = ua;
    r.id_use_regb  = ub;
    r.branch_taken = br;
    r.ram_pause    = rp;
    return r;
  endfunction

  task automatic check(input string name, input logic [3:0] ap, input logic [3:0] af,
                       input logic ab, input logic [3:0] ep, input logic [3:0] ef,
                       input logic eb);
    n_vec++;
    if ({ap, af, ab} !== {ep, ef, eb}) begin
      n_err++;
      $display("FAIL %s: got pause=%b flush=%b busy=%b, expected pause=%b flush=%b busy=%b",
               name, ap, af, ab, ep, ef, eb);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive both instances at the falling edge and settle before sampling.
  task automatic step(input in_t a, input in_t b);
    @(negedge clk);
    in1 = a;
    in3 = b;
    #2;
  endtask

  initial begin
    idle_in = mk(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    in1 = idle_in;
    in3 = idle_in;

    vecs[0]  = '{"idle",          idle_in,                                                               4'b0000, 4'b0000};
    vecs[1]  = '{"haz_a_r3",      mk(1'b1, 1'b1, 4'd3, 4'd3, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0),              4'b0011, 4'b0100};
    vecs[2]  = '{"no_use_a",      mk(1'b1, 1'b1, 4'd3, 4'd3, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0),              4'b0000, 4'b0000};
    vecs[3]  = '{"not_load",      mk(1'b1, 1'b0, 4'd3, 4'd3, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0),              4'b0000, 4'b0000};
    vecs[4]  = '{"no_reg_wr",     mk(1'b0, 1'b1, 4'd3, 4'd3, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0),              4'b0000, 4'b0000};
    vecs[5]  = '{"haz_b_r5",      mk(1'b1, 1'b1, 4'd5, 4'd1, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0),              4'b0011, 4'b0100};
    vecs[6]  = '{"haz_r0",        mk(1'b1, 1'b1, 4'd0, 4'd0, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0),              4'b0011, 4'b0100};
    vecs[7]  = '{"addr_miss",     mk(1'b1, 1'b1, 4'd6, 4'd2, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0),              4'b0000, 4'b0000};
    vecs[8]  = '{"branch",        mk(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0),              4'b0000, 4'b0110};
    vecs[9]  = '{"branch_haz",    mk(1'b1, 1'b1, 4'd3, 4'd3, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0),              4'b0000, 4'b0110};
    vecs[10] = '{"ram_all",       mk(1'b1, 1'b1, 4'd3, 4'd3, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1),              4'b1111, 4'b0000};
    vecs[11] = '{"ram_only",      mk(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1),              4'b1111, 4'b0000};
    vecs[12] = '{"haz_b_unused",  mk(1'b1, 1'b1, 4'd8, 4'd2, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0),              4'b0000, 4'b0000};
    vecs[13] = '{"idle_again",    idle_in,                                                               4'b0000, 4'b0000};

    // Reset state with inputs idle.
    #2;
    check("rst_lat1", pause1, flush1, busy1, 4'b0000, 4'b0000, 1'b0);
    check("rst_lat3", pause3, flush3, busy3, 4'b0000, 4'b0000, 1'b0);
`ifdef STALL_PERF_EN
    check32("rst_perf_ram", ram3, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // LOAD_LAT=1 table: never leaves IDLE, so each vector is independent.
    for (int i = 0; i < 14; i++) begin
      step(vecs[i].in, idle_in);
      check(vecs[i].name, pause1, flush1, busy1, vecs[i].pause, vecs[i].flush, 1'b0);
    end
    step(idle_in, idle_in);
    check("lat1_after", pause1, flush1, busy1, 4'b0000, 4'b0000, 1'b0);
    check("lat3_quiet", pause3, flush3, busy3, 4'b0000, 4'b0000, 1'b0);

    // LOAD_LAT=3, hazard on B, dropped after the first cycle.
    step(idle_in, mk(1'b1, 1'b1, 4'd4, 4'd1, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0));
    check("l3_c1", pause3, flush3, busy3, 4'b0011, 4'b0100, 1'b0);
    step(idle_in, idle_in);
    check("l3_c2", pause3, flush3, busy3, 4'b0011, 4'b0100, 1'b1);
    step(idle_in, idle_in);
    check("l3_c3", pause3, flush3, busy3, 4'b0011, 4'b0100, 1'b1);
    step(idle_in, idle_in);
    check("l3_c4", pause3, flush3, busy3, 4'b0000, 4'b0000, 1'b0);

    // ram_pause for two cycles in stall cycle 2, then the last two bubbles.
    step(idle_in, mk(1'b1, 1'b1, 4'd2, 4'd2, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    check("rp_c1", pause3, flush3, busy3, 4'b0011, 4'b0100, 1'b0);
    step(idle_in, mk(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    check("rp_p1", pause3, flush3, busy3, 4'b1111, 4'b0000, 1'b1);
    step(idle_in, mk(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    check("rp_p2", pause3, flush3, busy3, 4'b1111, 4'b0000, 1'b1);
    step(idle_in, idle_in);
    check("rp_c2", pause3, flush3, busy3, 4'b0011, 4'b0100, 1'b1);
    step(idle_in, idle_in);
    check("rp_c3", pause3, flush3, busy3, 4'b0011, 4'b0100, 1'b1);
    step(idle_in, idle_in);
    check("rp_done", pause3, flush3, busy3, 4'b0000, 4'b0000, 1'b0);

    // Branch in stall cycle 2 cancels the rest.
    step(idle_in, mk(1'b1, 1'b1, 4'd7, 4'd7, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    check("br_c1", pause3, flush3, busy3, 4'b0011, 4'b0100, 1'b0);
    step(idle_in, mk(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    check("br_c2", pause3, flush3, busy3, 4'b0000, 4'b0110, 1'b1);
    step(idle_in, idle_in);
    check("br_after", pause3, flush3, busy3, 4'b0000, 4'b0000, 1'b0);

    // Reset pulse mid-stall abandons the remaining bubble.
    step(idle_in, mk(1'b1, 1'b1, 4'd1, 4'd0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0));
    check("rs_c1", pause3, flush3, busy3, 4'b0011, 4'b0100, 1'b0);
    step(idle_in, idle_in);
    check("rs_c2", pause3, flush3, busy3, 4'b0011, 4'b0100, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    check("rs_async", pause3, flush3, busy3, 4'b0000, 4'b0000, 1'b0);
`ifdef STALL_PERF_EN
    check32("rs_perf_ram", ram3, 32'd0);
    check32("rs_perf_load", load3, 32'd0);
    check32("rs_perf_flush", fl3, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("rs_release", pause3, flush3, busy3, 4'b0000, 4'b0000, 1'b0);

    // Five ram_pause cycles, then one branch event.
    for (int i = 0; i < 5; i++) begin
      step(idle_in, mk(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    end
    step(idle_in, mk(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    check("post_branch", pause3, flush3, busy3, 4'b0000, 4'b0110, 1'b0);
    step(idle_in, idle_in);
`ifdef STALL_PERF_EN
    check32("perf_ram5", ram3, 32'd5);
    check32("perf_load0", load3, 32'd0);
    check32("perf_flush1", fl3, 32'd1);
`endif
    check("final_idle", pause3, flush3, busy3, 4'b0000, 4'b0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
